// File: rtl/downstream_cancel_tracker_pkg.sv
// Shared widths, cancel-event record and controller state encoding.
package downstream_cancel_tracker_pkg;

   localparam int CLIENT_W    = 5;
   localparam int AMOUNT_W    = 16;
   localparam int NUM_CLIENTS = 32;

   typedef struct packed {
      logic [CLIENT_W-1:0] client_id;
      logic [AMOUNT_W-1:0] amount;
   } cancel_evt_t;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_UPDATE = 2'd2
   } state_t;

endpackage

// File: rtl/downstream_cancel_tracker_fifo.sv
// Small synchronous FIFO for cancel events; head word is visible combinationally.
module cancel_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 21
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/downstream_cancel_tracker.sv
// Per-client cancelled-amount table fed by a buffered cancel-event stream.
//
// state     | meaning
// ST_INIT   | sweep table to zero, one entry per cycle; no events accepted
// ST_IDLE   | pop next buffered event into the holding register if any
// ST_UPDATE | add held amount to its entry (saturating) and write back
module downstream_cancel_tracker
   import downstream_cancel_tracker_pkg::CLIENT_W;
   import downstream_cancel_tracker_pkg::AMOUNT_W;
   import downstream_cancel_tracker_pkg::cancel_evt_t;
   import downstream_cancel_tracker_pkg::state_t;
   import downstream_cancel_tracker_pkg::ST_INIT;
   import downstream_cancel_tracker_pkg::ST_IDLE;
   import downstream_cancel_tracker_pkg::ST_UPDATE;
#(
   parameter int NUM_CLIENTS = 32,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                clk,
   input  logic                HRESETn,
   input  logic                cxl_valid,
   output logic                cxl_ready,
   input  logic [CLIENT_W-1:0] cxl_client_id,
   input  logic [AMOUNT_W-1:0] cxl_amount,
   input  logic                clr_valid,
   input  logic [CLIENT_W-1:0] clr_client_id,
   input  logic [CLIENT_W-1:0] rd_client_id,
   output logic [AMOUNT_W-1:0] cancelled_orders,
   output logic                init_done,
   output logic                sat_pulse
);

   localparam logic [CLIENT_W-1:0] LAST_IDX = CLIENT_W'(NUM_CLIENTS - 1);

   state_t              state;
   state_t              state_nxt;
   logic [CLIENT_W-1:0] sweep_idx;
   cancel_evt_t         hold;
   cancel_evt_t         fifo_head;
   cancel_evt_t         fifo_in;
   logic                fifo_full;
   logic                fifo_empty;
   logic                push;
   logic                pop;
   logic [AMOUNT_W-1:0] entry [NUM_CLIENTS];
   logic                wr_en;
   logic [CLIENT_W-1:0] wr_idx;
   logic [AMOUNT_W-1:0] wr_data;
   logic [AMOUNT_W-1:0] base;
   logic [AMOUNT_W:0]   sum;
   logic                upd_sat;

   assign init_done         = (state != ST_INIT);
   assign cxl_ready         = init_done && !fifo_full;
   assign push              = cxl_valid && cxl_ready;
   assign fifo_in.client_id = cxl_client_id;
   assign fifo_in.amount    = cxl_amount;

   cancel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(cancel_evt_t))
   ) u_fifo (
      .clk   (clk),
      .rst_n (HRESETn),
      .push  (push),
      .din   (fifo_in),
      .pop   (pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next state and arbitration of the single table write port.
   // A clear of another client during UPDATE takes the port and holds the
   // update one more cycle so neither the clear nor the cancel is lost.
   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      wr_idx    = hold.client_id;
      wr_data   = '0;
      pop       = 1'b0;
      upd_sat   = 1'b0;
      base      = (clr_valid && (clr_client_id == hold.client_id)) ? '0 : entry[hold.client_id];
      sum       = {1'b0, base} + {1'b0, hold.amount};
      case (state)
         ST_INIT: begin
            wr_en  = 1'b1;
            wr_idx = sweep_idx;
            if (sweep_idx == LAST_IDX) state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (clr_valid) begin
               wr_en  = 1'b1;
               wr_idx = clr_client_id;
            end
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            wr_en = 1'b1;
            if (clr_valid && (clr_client_id != hold.client_id)) begin
               wr_idx = clr_client_id;
            end else begin
               wr_data   = sum[AMOUNT_W] ? '1 : sum[AMOUNT_W-1:0];
               upd_sat   = sum[AMOUNT_W];
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   // Control registers, holding register, saturation pulse and write-first lookup.
   always_ff @(posedge clk or negedge HRESETn) begin
      if (!HRESETn) begin
         state            <= ST_INIT;
         sweep_idx        <= '0;
         hold             <= '0;
         sat_pulse        <= 1'b0;
         cancelled_orders <= '0;
      end else begin
         state     <= state_nxt;
         sat_pulse <= upd_sat;
         if (state == ST_INIT) sweep_idx <= sweep_idx + 1'b1;
         if (pop) hold <= fifo_head;
         if (state == ST_INIT)
            cancelled_orders <= '0;
         else if (wr_en && (wr_idx == rd_client_id))
            cancelled_orders <= wr_data;
         else
            cancelled_orders <= entry[rd_client_id];
      end
   end

   // Table storage; zeroed by the INIT sweep rather than by reset.
   always_ff @(posedge clk) begin
      if (wr_en) entry[wr_idx] <= wr_data;
   end

endmodule
